hilo_muldiv_unit: RTL
=====================

# hilo_muldiv_unit

Multi-cycle HI/LO execution unit for the MIPS54 multicycle core. It sits directly downstream of the combinational 32x32 multiplier. It registers the multiplier's 64-bit product into the architectural HI/LO registers, runs an iterative 32-step divider for DIV/DIVU, and services MTHI/MTLO. The core's control FSM drives it through a start/busy/done handshake; MFHI/MFLO read `hi`/`lo` directly.

## Interface
Parameters:
- `DIV_STEPS`, default 32: radix-2 divide iterations; equals the operand width and is not overridden.

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  op request; sampled only in IDLE
- `op`  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6/7 ignored
- `rs_data`  in  32  operand A / dividend / MTHI-MTLO source
- `rt_data`  in  32  operand B / divisor
- `mul_sign`  out  1  sign select to the multiplier (1 for MULT)
- `mul_a`, `mul_b`  out  32  latched operands to the multiplier
- `mul_z`  in  64  multiplier product
- `busy`  out  1  high from the edge that accepts an op through the DONE cycle
- `done`  out  1  one-cycle pulse, in DONE state
- `div_zero`  out  1  sticky flag; last DIV/DIVU had divisor 0; cleared by the next accepted MULT/MULTU/DIV/DIVU
- `hi`, `lo`  out  32  architectural HI/LO

Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, `div_zero`=0, `mul_a`=0, `mul_b`=0, `mul_sign`=0, state IDLE.

## Operation
- States: IDLE, MUL, MUL2 (only if pipelined), DIV, DFIX, DONE.
- IDLE, `start`=1:
  - MULT/MULTU/DIV/DIVU: latch operands and the signed flag; go to MUL or DIV.
  - MTHI/MTLO: write `hi`/`lo` at the same edge. Stay IDLE. No busy, no done.
  - Op 6/7: ignored.
- `start` outside IDLE is ignored. It is neither queued nor errored.
- MUL: `{hi,lo}` ← `mul_z` at the exit edge. Multiplier inputs are driven only from the latched registers, never from `rs_data`/`rt_data`.
- DIV:
  - On entry, if divisor is 0, set `div_zero`, leave `hi`/`lo` unchanged, and go straight to DONE.
  - Otherwise take absolute values (signed case only) and run a restoring shift-subtract: 33-bit partial remainder, one quotient bit per cycle, MSB first, with a 5-bit step counter from 31 down to 0.
- DFIX:
  - Signed case: negate the quotient if the operand signs differ; the remainder takes the sign of the dividend.
  - Write `lo`=quotient, `hi`=remainder.
- Signed 0x80000000 / 0xFFFFFFFF gives `lo`=0x80000000, `hi`=0 (two's-complement wrap, no trap).
- DONE: `done`=1 for one cycle, then IDLE. A new `start` is accepted on the following cycle at the earliest.
- `rst_n` low at any time, mid-divide included, returns immediately to reset values. The partial result is discarded.

## Timing
- E0 = the edge accepting `start`.
- MULT/MULTU, unpipelined: `hi`/`lo` update at E1; `done` during E1–E2.
- MULT/MULTU, pipelined: `hi`/`lo` update at E2; `done` during E2–E3.
- DIV/DIVU: iterations at E1..E32, write at E33, `done` during E33–E34. Total 34 cycles including DONE.
- Divide by zero: `done` during E1–E2; `hi`/`lo` untouched.
- MTHI/MTLO: visible on `hi`/`lo` the cycle after E0.

## Configuration
- `HILO_MUL_PIPE_EN` defined:
  - Inserts MUL2.
  - `mul_z` is registered at E1 and written to HI/LO at E2.
  - Breaks the long combinational multiplier path for timing closure.
- Undefined:
  - MUL2 is absent.
  - `mul_z` is written directly at E1.
- Divide, MTHI/MTLO and handshake behaviour are identical in both builds.

## Structure
- Shared package `hilo_pkg`:
  - op encodings `OP_MULT`..`OP_MTLO`
  - state enum
  - `DIV_STEPS` constant
- Sub-module `div_core`: the iterative divider, with signed fix-up and zero detect. Its interface is start/busy/quotient/remainder/dz.
- The parent holds the FSM, HI/LO and the multiplier interface.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> `hi`=0xFFFFFFFE, `lo`=0x00000001; `done` at cycle 1 (2 with `HILO_MUL_PIPE_EN`).
- MULT -3 × 5 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1; `mul_sign`=1 while busy.
- DIV -7 / 2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF, `done` 33 cycles after E0. DIVU 100 / 7 -> `lo`=14, `hi`=2.
- DIV 0x80000000 / 0xFFFFFFFF -> `lo`=0x80000000, `hi`=0. DIVU 5 / 0 -> `div_zero`=1, `hi`/`lo` unchanged, `done` at cycle 1.
- MTHI 0x12345678 while idle -> `hi`=0x12345678 next cycle, no `done`. `start` with MTLO asserted mid-DIV -> ignored, `lo` holds the divide result.
- `rst_n` low at iteration 10 of DIVU -> all outputs return to 0 immediately. A MULTU 2×3 issued after release -> `lo`=6.

Source files
------------

// File: rtl/hilo_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit.
// Optional feature macro: HILO_MUL_PIPE_EN (registers the product before HI/LO).
package hilo_pkg;

  localparam int DIV_STEPS = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_MUL2,
    ST_DIV,
    ST_DFIX,
    ST_DONE
  } state_e;

endpackage

// File: rtl/hilo_muldiv_unit_div_core.sv
// Iterative restoring divider: one quotient bit per cycle, MSB first,
// with signed fix-up of quotient/remainder and divisor-zero detect.
module div_core
  import hilo_pkg::*;
#(
  parameter int W = hilo_pkg::DIV_STEPS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic         signed_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         busy_o,
  output logic         last_o,
  output logic         dz_o,
  output logic [W-1:0] quot_o,
  output logic [W-1:0] rem_o
);

  localparam int CW = $clog2(W);

  logic [W-1:0]  q_q;
  logic [W:0]    r_q;
  logic [W-1:0]  b_q;
  logic [CW-1:0] cnt_q;
  logic          run_q;
  logic          qneg_q;
  logic          rneg_q;
  logic          dz_q;

  logic          a_neg;
  logic          b_neg;
  logic [W-1:0]  a_abs;
  logic [W-1:0]  b_abs;
  logic [W:0]    shifted;
  logic [W+1:0]  diff;

  assign a_neg = signed_i & a_i[W-1];
  assign b_neg = signed_i & b_i[W-1];
  assign a_abs = a_neg ? -a_i : a_i;
  assign b_abs = b_neg ? -b_i : b_i;

  // Shift the next dividend bit in, then trial-subtract the divisor.
  assign shifted = {r_q[W-1:0], q_q[W-1]};
  assign diff    = {1'b0, shifted} - {2'b00, b_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q    <= '0;
      r_q    <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
    end else if (start_i) begin
      q_q    <= a_abs;
      r_q    <= '0;
      b_q    <= b_abs;
      cnt_q  <= CW'(W - 1);
      run_q  <= (b_i != '0);
      qneg_q <= a_neg ^ b_neg;
      rneg_q <= a_neg;
      dz_q   <= (b_i == '0);
    end else if (run_q) begin
      if (diff[W+1]) begin
        r_q <= shifted;
        q_q <= {q_q[W-2:0], 1'b0};
      end else begin
        r_q <= diff[W:0];
        q_q <= {q_q[W-2:0], 1'b1};
      end
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == '0) run_q <= 1'b0;
    end
  end

  assign busy_o = run_q;
  assign last_o = run_q && (cnt_q == '0);
  assign dz_o   = dz_q;
  assign quot_o = qneg_q ? -q_q : q_q;
  assign rem_o  = rneg_q ? -r_q[W-1:0] : r_q[W-1:0];

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO execution unit: product capture, iterative divide, MTHI/MTLO.
// Optional macro HILO_MUL_PIPE_EN adds a product register stage (MUL2).
module hilo_muldiv_unit
  import hilo_pkg::*;
#(
  parameter int DIV_STEPS = hilo_pkg::DIV_STEPS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        mul_sign,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_z,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_e      state_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] mul_a_q;
  logic [31:0] mul_b_q;
  logic        mul_sign_q;
  logic        busy_q;
  logic        done_q;
  logic        dz_q;
`ifdef HILO_MUL_PIPE_EN
  logic [63:0] prod_q;
`endif

  logic        idle_go;
  logic        is_mul;
  logic        is_div;
  logic        is_mthi;
  logic        is_mtlo;
  logic        div_busy;
  logic        div_last;
  logic        div_dz;
  logic [31:0] div_quot;
  logic [31:0] div_rem;

  assign idle_go = (state_q == ST_IDLE) && start;
  assign is_mul  = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div  = (op == OP_DIV) || (op == OP_DIVU);
  assign is_mthi = (op == OP_MTHI);
  assign is_mtlo = (op == OP_MTLO);

  div_core #(
    .W (DIV_STEPS)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (idle_go && is_div),
    .signed_i (op == OP_DIV),
    .a_i      (rs_data),
    .b_i      (rt_data),
    .busy_o   (div_busy),
    .last_o   (div_last),
    .dz_o     (div_dz),
    .quot_o   (div_quot),
    .rem_o    (div_rem)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      hi_q       <= '0;
      lo_q       <= '0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      mul_sign_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dz_q       <= 1'b0;
`ifdef HILO_MUL_PIPE_EN
      prod_q     <= '0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            unique case (1'b1)
              is_mul: begin
                mul_a_q    <= rs_data;
                mul_b_q    <= rt_data;
                mul_sign_q <= (op == OP_MULT);
                dz_q       <= 1'b0;
                busy_q     <= 1'b1;
                state_q    <= ST_MUL;
              end
              is_div: begin
                dz_q    <= 1'b0;
                busy_q  <= 1'b1;
                state_q <= ST_DIV;
              end
              is_mthi: hi_q <= rs_data;
              is_mtlo: lo_q <= rs_data;
              default: ;
            endcase
          end
        end
`ifdef HILO_MUL_PIPE_EN
        ST_MUL: begin
          prod_q  <= mul_z;
          state_q <= ST_MUL2;
        end
        ST_MUL2: begin
          {hi_q, lo_q} <= prod_q;
          done_q       <= 1'b1;
          state_q      <= ST_DONE;
        end
`else
        ST_MUL: begin
          {hi_q, lo_q} <= mul_z;
          done_q       <= 1'b1;
          state_q      <= ST_DONE;
        end
`endif
        ST_DIV: begin
          // Zero divisor: the divider never starts, skip straight to DONE.
          if (div_dz) begin
            dz_q    <= 1'b1;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else if (div_last) begin
            state_q <= ST_DFIX;
          end
        end
        ST_DFIX: begin
          hi_q    <= div_rem;
          lo_q    <= div_quot;
          done_q  <= 1'b1;
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mul_sign = mul_sign_q;
  assign mul_a    = mul_a_q;
  assign mul_b    = mul_b_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
